// File: rtl/uart_rx_sample_counter.sv
// UART RX bit/frame timing engine: edge counter per bit, bit counter per frame, mid-bit strobe decode.
// Define UART_RX_TRIPLE_SAMPLE_EN for three strobes around mid-bit plus sample_idx_out.
module uart_rx_sample_counter #(
   parameter int unsigned PRESCALE_W = 6,
   parameter int unsigned BIT_CNT_W  = 4,
   parameter int unsigned FRAME_BITS = 11
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [PRESCALE_W-1:0] prescale_in,
   input  logic                  start_in,
   input  logic                  stop_in,
   input  logic                  en_in,
   output logic [PRESCALE_W-1:0] edge_cnt_out,
   output logic [BIT_CNT_W-1:0]  bit_cnt_out,
   output logic                  busy_out,
   output logic                  sample_stb_out,
   output logic                  bit_done_out,
   output logic                  frame_done_out,
   output logic                  cfg_err_out
`ifdef UART_RX_TRIPLE_SAMPLE_EN
   ,
   output logic [1:0]            sample_idx_out
`endif
);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

`ifdef UART_RX_TRIPLE_SAMPLE_EN
   localparam logic [PRESCALE_W-1:0] MIN_PRESCALE = PRESCALE_W'(6);
`else
   localparam logic [PRESCALE_W-1:0] MIN_PRESCALE = PRESCALE_W'(4);
`endif
   localparam logic [PRESCALE_W-1:0] P_ONE    = PRESCALE_W'(1);
   localparam logic [BIT_CNT_W-1:0]  B_ONE    = BIT_CNT_W'(1);
   localparam logic [BIT_CNT_W-1:0]  LAST_BIT = BIT_CNT_W'(FRAME_BITS - 1);

   state_t                  state, state_d;
   logic [PRESCALE_W-1:0]   prescale_q, prescale_d;
   logic [PRESCALE_W-1:0]   edge_cnt, edge_d;
   logic [BIT_CNT_W-1:0]    bit_cnt, bit_d;
   logic                    cfg_err, cfg_err_d;
   logic [PRESCALE_W-1:0]   mid;
   logic                    last_edge;
   logic                    last_bit;
   logic                    active;

   assign mid       = prescale_q >> 1;
   assign last_edge = (edge_cnt == prescale_q - P_ONE);
   assign last_bit  = (bit_cnt == LAST_BIT);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         prescale_q <= '0;
         edge_cnt   <= '0;
         bit_cnt    <= '0;
         cfg_err    <= 1'b0;
      end else begin
         state      <= state_d;
         prescale_q <= prescale_d;
         edge_cnt   <= edge_d;
         bit_cnt    <= bit_d;
         cfg_err    <= cfg_err_d;
      end
   end

   // Priority: stop over start over counting; a rejected start leaves prescale_q untouched.
   always_comb begin
      state_d    = state;
      prescale_d = prescale_q;
      edge_d     = edge_cnt;
      bit_d      = bit_cnt;
      cfg_err_d  = cfg_err;
      if (stop_in) begin
         state_d = IDLE;
         edge_d  = '0;
         bit_d   = '0;
      end else if (start_in) begin
         edge_d = '0;
         bit_d  = '0;
         if (prescale_in >= MIN_PRESCALE) begin
            prescale_d = prescale_in;
            cfg_err_d  = 1'b0;
            state_d    = RUN;
         end else begin
            cfg_err_d = 1'b1;
            state_d   = IDLE;
         end
      end else if (state == RUN && en_in) begin
         if (last_edge) begin
            edge_d = '0;
            if (last_bit) begin
               bit_d   = '0;
               state_d = IDLE;
            end else begin
               bit_d = bit_cnt + B_ONE;
            end
         end else begin
            edge_d = edge_cnt + P_ONE;
         end
      end
   end

   always_comb begin
      active         = (state == RUN) && en_in;
      edge_cnt_out   = edge_cnt;
      bit_cnt_out    = bit_cnt;
      busy_out       = (state == RUN);
      cfg_err_out    = cfg_err;
      bit_done_out   = active && last_edge;
      frame_done_out = active && last_edge && last_bit;
`ifdef UART_RX_TRIPLE_SAMPLE_EN
      sample_stb_out = 1'b0;
      sample_idx_out = '0;
      if (active) begin
         if (edge_cnt == mid - P_ONE) begin
            sample_stb_out = 1'b1;
            sample_idx_out = 2'd0;
         end else if (edge_cnt == mid) begin
            sample_stb_out = 1'b1;
            sample_idx_out = 2'd1;
         end else if (edge_cnt == mid + P_ONE) begin
            sample_stb_out = 1'b1;
            sample_idx_out = 2'd2;
         end
      end
`else
      sample_stb_out = active && (edge_cnt == mid);
`endif
   end

endmodule
